// File: rtl/ita_input_row_packer.sv
// ita_input_row_packer
//   Producer side of the ITA input buffer write port. Collects a narrow
//   valid/ready byte stream (BeatBytes bytes per beat) into full embedding
//   rows and issues one row write per sequence position, at addresses
//   0 .. seq_length-1.
//
// Configuration:
//   ITA_PACKER_DBUF_EN - when defined, the next row is assembled while the
//   previous row waits for write_ready_i (assembly buffer + write buffer
//   act as a ping-pong pair). When undefined, the input stalls for the
//   whole time a row sits in WRITE.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous abort back to IDLE (drops any partial row)
//   start_i         one-cycle start pulse, seq_length_i/embed_size_i sampled
//   in_*            input beat stream, byte 0 in the LSBs
//   write_*         row write request: address, row data (element 0 in LSBs)
//   busy_o          job in progress (FILL/WRITE/DONE)
//   done_o          one-cycle pulse at the end of a job
module ita_input_row_packer #(
  parameter  int S         = 64,
  parameter  int E         = 64,
  parameter  int WI        = 8,
  parameter  int BeatBytes = 16,
  localparam int AW        = (S > 1) ? $clog2(S) : 1,
  localparam int LW        = $clog2(S + 1),
  localparam int SW        = $clog2(E + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [LW-1:0]           seq_length_i,
  input  logic [SW-1:0]           embed_size_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [BeatBytes*WI-1:0] in_data_i,
  output logic                    write_valid_o,
  input  logic                    write_ready_i,
  output logic [AW-1:0]           write_addr_o,
  output logic [E*WI-1:0]         write_data_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int BprMax = E / BeatBytes;
  localparam int BW     = (BprMax > 1) ? $clog2(BprMax) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     seq_len_q, seq_len_d;
  logic [SW-1:0]     embed_q, embed_d;
  logic [BW-1:0]     last_beat_q, last_beat_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [AW-1:0]     row_q, row_d;
  logic [LW-1:0]     fill_row_q, fill_row_d;
  logic [E*WI-1:0]   buf_q, buf_d;
  logic [E*WI-1:0]   wdata_q, wdata_d;
  logic              wv_q, wv_d;
  logic              asm_full_q, asm_full_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [E*WI-1:0]   merged_s;
  logic              accept_s;
  logic              wr_hs_s;
  logic              last_row_s;
  logic              job_done_s;
  logic              active_s;

  assign accept_s   = in_ready_q & in_valid_i;
  assign wr_hs_s    = wv_q & write_ready_i;
  assign last_row_s = (LW'(row_q) == (seq_len_q - LW'(1)));

  // Assembly buffer with the current beat merged into slot beat_q; bytes at
  // or beyond embed_q are forced to zero so a short last beat leaves no junk.
  always_comb begin
    merged_s = buf_q;
    for (int i = 0; i < E; i++) begin
      if (beat_q == BW'(i / BeatBytes)) begin
        if (i < int'(embed_q)) begin
          merged_s[i*WI +: WI] = in_data_i[(i % BeatBytes)*WI +: WI];
        end else begin
          merged_s[i*WI +: WI] = '0;
        end
      end else begin
        merged_s[i*WI +: WI] = buf_q[i*WI +: WI];
      end
    end
  end

  // Next-state and datapath control for the job FSM.
  always_comb begin
    state_d     = state_q;
    seq_len_d   = seq_len_q;
    embed_d     = embed_q;
    last_beat_d = last_beat_q;
    beat_d      = beat_q;
    row_d       = row_q;
    fill_row_d  = fill_row_q;
    buf_d       = buf_q;
    wdata_d     = wdata_q;
    wv_d        = wv_q;
    asm_full_d  = asm_full_q;
    job_done_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          seq_len_d  = seq_length_i;
          embed_d    = (embed_size_i > SW'(E)) ? SW'(E) : embed_size_i;
          row_d      = '0;
          fill_row_d = '0;
          beat_d     = '0;
          buf_d      = '0;
          wdata_d    = '0;
          wv_d       = 1'b0;
          asm_full_d = 1'b0;
          if ((seq_length_i == '0) || (embed_d == '0)) begin
            state_d = ST_DONE;
          end else begin
            last_beat_d = BW'((int'(embed_d) + BeatBytes - 1) / BeatBytes - 1);
            state_d     = ST_FILL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FILL, ST_WRITE: begin
        // Write side first: a completed handshake frees the write buffer,
        // and a row parked in the assembly buffer moves straight into it.
        if (wr_hs_s) begin
          wv_d = 1'b0;
          if (last_row_s) begin
            job_done_s = 1'b1;
            row_d      = '0;
          end else begin
            row_d = row_q + AW'(1);
          end
          if (asm_full_q) begin
            wdata_d    = buf_q;
            wv_d       = 1'b1;
            asm_full_d = 1'b0;
            buf_d      = '0;
          end else begin
            wdata_d = wdata_q;
          end
        end else begin
          wv_d = wv_q;
        end

        // Input side: in_ready_q is never set while a row is parked, so the
        // parked-row transfer above and a beat accept cannot collide.
        if (accept_s) begin
          if (beat_q == last_beat_q) begin
            beat_d     = '0;
            fill_row_d = fill_row_q + LW'(1);
            if (!wv_q || wr_hs_s) begin
              wdata_d = merged_s;
              wv_d    = 1'b1;
              buf_d   = '0;
            end else begin
              buf_d      = merged_s;
              asm_full_d = 1'b1;
            end
          end else begin
            buf_d  = merged_s;
            beat_d = beat_q + BW'(1);
          end
        end else begin
          beat_d = beat_q;
        end

        if (job_done_s) begin
          state_d = ST_DONE;
          wdata_d = '0;
        end else if (wv_d) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_FILL;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over every other event in the same cycle.
    if (clear_i) begin
      state_d    = ST_IDLE;
      wv_d       = 1'b0;
      asm_full_d = 1'b0;
      buf_d      = '0;
      wdata_d    = '0;
      beat_d     = '0;
      row_d      = '0;
      fill_row_d = '0;
    end else begin
      state_d = state_d;
    end
  end

  // Registered handshake/status outputs derived from the next state.
  always_comb begin
    active_s = (state_d == ST_FILL) || (state_d == ST_WRITE);
`ifdef ITA_PACKER_DBUF_EN
    in_ready_d = active_s && (fill_row_d < seq_len_d) && !asm_full_d;
`else
    in_ready_d = active_s && !wv_d;
`endif
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      seq_len_q   <= '0;
      embed_q     <= '0;
      last_beat_q <= '0;
      beat_q      <= '0;
      row_q       <= '0;
      fill_row_q  <= '0;
      buf_q       <= '0;
      wdata_q     <= '0;
      wv_q        <= 1'b0;
      asm_full_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_len_q   <= seq_len_d;
      embed_q     <= embed_d;
      last_beat_q <= last_beat_d;
      beat_q      <= beat_d;
      row_q       <= row_d;
      fill_row_q  <= fill_row_d;
      buf_q       <= buf_d;
      wdata_q     <= wdata_d;
      wv_q        <= wv_d;
      asm_full_q  <= asm_full_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign write_valid_o = wv_q;
  assign write_addr_o  = row_q;
  assign write_data_o  = wdata_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_ita_input_row_packer.sv
module tb_ita_input_row_packer;

  localparam int E  = 64;
  localparam int NB = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [6:0]   seq_len = '0;
  logic [6:0]   embed = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         write_valid;
  logic         write_ready = 1'b0;
  logic [5:0]   write_addr;
  logic [511:0] write_data;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int exp_done = 0;

  typedef struct {
    logic [5:0]   addr;
    logic [511:0] data;
  } exp_t;
  exp_t sb[$];

  ita_input_row_packer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .start_i      (start),
    .seq_length_i (seq_len),
    .embed_size_i (embed),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .write_valid_o(write_valid),
    .write_ready_i(write_ready),
    .write_addr_o (write_addr),
    .write_data_o (write_data),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_beat(input int first);
    logic [127:0] r;
    for (int k = 0; k < NB; k++) r[k*8 +: 8] = 8'(first + k);
    return r;
  endfunction

  function automatic logic [511:0] mk_row(input int first, input int emb);
    logic [511:0] r;
    for (int i = 0; i < E; i++) r[i*8 +: 8] = (i < emb) ? 8'(first + i) : 8'h00;
    return r;
  endfunction

  // Scoreboard: every accepted row write is checked against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (write_valid && write_ready) begin
      chk("sb_nonempty", 1'(sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_addr", write_addr, e.addr);
        chk("wr_data", write_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int seq, input int emb);
    seq_len = 7'(seq);
    embed   = 7'(emb);
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        step();
        break;
      end
    end
    in_valid = 1'b0;
    chk("beat_accepted", ok, 1'b1);
  endtask

  // Full job with write_ready held high; checks write latency and done timing.
  task automatic run_job(input int seq, input int emb, input int base);
    int eff = (emb > E) ? E : emb;
    int bpr = (eff + NB - 1) / NB;
    exp_t e;
    for (int r = 0; r < seq; r++) begin
      e.addr = 6'(r);
      e.data = mk_row(base + r * bpr * NB, eff);
      sb.push_back(e);
    end
    do_start(seq, emb);
    for (int r = 0; r < seq; r++) begin
      for (int b = 0; b < bpr; b++) send_beat(mk_beat(base + (r * bpr + b) * NB));
      @(negedge clk);
      chk("wv_after_last_beat", write_valid, 1'b1);
      chk("addr_after_last_beat", write_addr, 6'(r));
`ifndef ITA_PACKER_DBUF_EN
      chk("ready_low_in_write", in_ready, 1'b0);
`endif
    end
    step();
    @(negedge clk);
    chk("done_pulse", done, 1'b1);
    exp_done++;
    step();
    @(negedge clk);
    chk("done_single_cycle", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    exp_t e;
    int   d0;
    bit   got;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_wv", write_valid, 1'b0);
    chk("rst_addr", write_addr, 6'd0);
    chk("rst_data", write_data, 512'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    write_ready = 1'b1;

    // Full rows, running byte count 0..191
    run_job(3, 64, 0);
    // Partial rows: 3 beats per row, tail bytes zeroed
    run_job(2, 40, 8'h10);
    // embed_size above E clamps to E
    run_job(1, 100, 8'h80);

    // Write stall for 5 cycles: outputs held stable
    write_ready = 1'b0;
    e.addr = 6'd0;
    e.data = mk_row(8'h40, 16);
    sb.push_back(e);
    do_start(1, 16);
    send_beat(mk_beat(8'h40));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_wv", write_valid, 1'b1);
      chk("stall_addr", write_addr, 6'd0);
      chk("stall_data", write_data, e.data);
`ifndef ITA_PACKER_DBUF_EN
      chk("stall_in_ready", in_ready, 1'b0);
`endif
      step();
    end
    write_ready = 1'b1;
    step();
    @(negedge clk);
    chk("stall_done", done, 1'b1);
    exp_done++;
    step();

    // Zero-length jobs finish without any write
    do_start(0, 64);
    @(negedge clk);
    chk("seq0_done", done, 1'b1);
    chk("seq0_wv", write_valid, 1'b0);
    chk("seq0_busy", busy, 1'b1);
    exp_done++;
    step();
    @(negedge clk);
    chk("seq0_idle", busy, 1'b0);
    step();
    do_start(3, 0);
    @(negedge clk);
    chk("emb0_done", done, 1'b1);
    chk("emb0_wv", write_valid, 1'b0);
    exp_done++;
    step();

    // Abort during beat 2 of row 1
    e.addr = 6'd0;
    e.data = mk_row(8'hA0, 64);
    sb.push_back(e);
    do_start(2, 64);
    for (int b = 0; b < 4; b++) send_beat(mk_beat(8'hA0 + b * NB));
    send_beat(mk_beat(8'hE0));
    send_beat(mk_beat(8'hF0));
    d0 = done_cnt;
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_busy", busy, 1'b0);
    chk("clr_wv", write_valid, 1'b0);
    chk("clr_in_ready", in_ready, 1'b0);
    step();
    step();
    @(negedge clk);
    chk("clr_no_done", 32'(done_cnt), 32'(d0));
    step();
    run_job(2, 64, 8'h33);

`ifdef ITA_PACKER_DBUF_EN
    // Ping-pong: two rows accepted while writes are blocked
    write_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      e.addr = 6'(r);
      e.data = mk_row(8'hC0 + r * NB, 16);
      sb.push_back(e);
    end
    do_start(4, 16);
    send_beat(mk_beat(8'hC0));
    send_beat(mk_beat(8'hD0));
    step();
    @(negedge clk);
    chk("dbuf_ready_drop", in_ready, 1'b0);
    chk("dbuf_wv", write_valid, 1'b1);
    chk("dbuf_addr", write_addr, 6'd0);
    write_ready = 1'b1;
    send_beat(mk_beat(8'hE0));
    send_beat(mk_beat(8'hF0));
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("dbuf_done", got, 1'b1);
    exp_done++;
    step();
`endif

    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
